robo_sensores: RTL and testbench

- Sensor front-end for the robot state machine. It sits directly upstream of that FSM and feeds its H, L, U and B inputs.
- Synchronises the four raw, asynchronous, bouncing sensor lines to the clock and debounces each one independently.
- Presents clean registered levels downstream, plus a change strobe, a stability flag and a saturating glitch counter for diagnostics.

---
 rtl/robo_pkg.sv | 23 ++
 rtl/robo_debounce_canal.sv | 61 ++++++
 rtl/robo_sensores.sv | 80 ++++++++
 tb/tb_robo_sensores.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared definitions for the robot sensor path: sensor bit positions and the
// debounce defaults that the robot FSM and the sensor front-end both rely on.
package robo_pkg;

    localparam int NUM_CH        = 4;
    localparam int IDX_H         = 3;
    localparam int IDX_L         = 2;
    localparam int IDX_U         = 1;
    localparam int IDX_B         = 0;

    localparam int DEBOUNCE_DEF  = 8;
    localparam int CNT_WIDTH_DEF = 4;

    function automatic logic [2:0] popcount4(input logic [NUM_CH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/robo_debounce_canal.sv
// One sensor channel: two-flop synchroniser, run-length debounce counter and
// the registered clean level, with per-edge accept/glitch strobes.
module robo_debounce_canal
    import robo_pkg::*;
#(
    parameter int DEBOUNCE  = DEBOUNCE_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic accept_o,
    output logic glitch_o,
    output logic busy_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE - 1);

    logic                 s1_q, s2_q;
    logic                 d_q, d_d;
    logic [CNT_WIDTH-1:0] c_q, c_d;

    always_comb begin
        c_d      = c_q;
        d_d      = d_q;
        accept_o = 1'b0;
        glitch_o = 1'b0;
        if (s2_q == d_q) begin
            // Falling back to the current level mid-count means the run was a glitch.
            if (c_q != '0) begin
                c_d      = '0;
                glitch_o = 1'b1;
            end
        end else if (c_q == LAST) begin
            d_d      = s2_q;
            c_d      = '0;
            accept_o = 1'b1;
        end else begin
            c_d = c_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
            c_q  <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            d_q  <= d_d;
            c_q  <= c_d;
        end
    end

    assign level_o = d_q;
    assign busy_o  = (c_q != '0);

endmodule

// File: rtl/robo_sensores.sv
// Sensor front-end: four independent debounced channels feeding H/L/U/B, plus
// a shared change pulse, stability flag and saturating glitch counter.
module robo_sensores
    import robo_pkg::*;
#(
    parameter int DEBOUNCE     = DEBOUNCE_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int GLITCH_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    raw_h,
    input  logic                    raw_l,
    input  logic                    raw_u,
    input  logic                    raw_b,
    input  logic                    clear_glitch,
    output logic                    H,
    output logic                    L,
    output logic                    U,
    output logic                    B,
    output logic                    changed,
    output logic                    stable,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    logic [NUM_CH-1:0] raw_vec, level, accept, glitch, busy;

    assign raw_vec[IDX_H] = raw_h;
    assign raw_vec[IDX_L] = raw_l;
    assign raw_vec[IDX_U] = raw_u;
    assign raw_vec[IDX_B] = raw_b;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        robo_debounce_canal #(
            .DEBOUNCE  (DEBOUNCE),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_canal (
            .clk_i    (clock),
            .rst_ni   (reset),
            .raw_i    (raw_vec[g]),
            .level_o  (level[g]),
            .accept_o (accept[g]),
            .glitch_o (glitch[g]),
            .busy_o   (busy[g])
        );
    end

    logic                    changed_q, changed_d;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic [GLITCH_WIDTH:0]   gsum;

    always_comb begin
        changed_d = |accept;
        // One extra bit catches overflow; at most four glitches arrive per edge.
        gsum      = {1'b0, glitch_q} + (GLITCH_WIDTH + 1)'(popcount4(glitch));
        glitch_d  = gsum[GLITCH_WIDTH] ? '1 : gsum[GLITCH_WIDTH-1:0];
        if (clear_glitch) begin
            glitch_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
            glitch_q  <= '0;
        end else begin
            changed_q <= changed_d;
            glitch_q  <= glitch_d;
        end
    end

    assign H            = level[IDX_H];
    assign L            = level[IDX_L];
    assign U            = level[IDX_U];
    assign B            = level[IDX_B];
    assign changed      = changed_q;
    assign stable       = ~|busy;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_robo_sensores.sv
// Bench for robo_sensores: table-driven rise check, hand-written corner
// sequences and a randomized run against a sample-window reference model.
module tb_robo_sensores;

    localparam int DEB  = 8;
    localparam int GMAX = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       raw_h = 1'b0, raw_l = 1'b0, raw_u = 1'b0, raw_b = 1'b0;
    logic       clear_glitch = 1'b0;
    logic       H, L, U, B, changed, stable;
    logic [7:0] glitch_count;

    robo_sensores #(.DEBOUNCE(DEB), .CNT_WIDTH(4), .GLITCH_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_h        (raw_h),
        .raw_l        (raw_l),
        .raw_u        (raw_u),
        .raw_b        (raw_b),
        .clear_glitch (clear_glitch),
        .H            (H),
        .L            (L),
        .U            (U),
        .B            (B),
        .changed      (changed),
        .stable       (stable),
        .glitch_count (glitch_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel's level flips once the last DEB decided
    // samples (raw delayed by two edges) all disagree with it.
    logic m_out [4];
    logic m_r1  [4];
    logic m_r2  [4];
    logic m_win [4][DEB];
    int   m_gc;
    logic m_chg;

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_out[ch] = 1'b0;
            m_r1[ch]  = 1'b0;
            m_r2[ch]  = 1'b0;
            for (int i = 0; i < DEB; i++) m_win[ch][i] = 1'b0;
        end
        m_gc  = 0;
        m_chg = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic clr);
        int   n;
        logic acc, x, pend, all_diff;
        n   = 0;
        acc = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            x    = m_r2[ch];
            pend = (m_win[ch][DEB-1] != m_out[ch]);
            for (int i = 0; i < DEB - 1; i++) m_win[ch][i] = m_win[ch][i+1];
            m_win[ch][DEB-1] = x;
            if (x == m_out[ch] && pend) n++;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_win[ch][i] == m_out[ch]) all_diff = 1'b0;
            if (all_diff) begin
                m_out[ch] = ~m_out[ch];
                acc = 1'b1;
            end
            m_r2[ch] = m_r1[ch];
            m_r1[ch] = raw[ch];
        end
        m_chg = acc;
        if (clr) m_gc = 0;
        else     m_gc = (m_gc + n > GMAX) ? GMAX : m_gc + n;
    endtask

    function automatic int model_stable();
        int s;
        s = 1;
        for (int ch = 0; ch < 4; ch++) if (m_win[ch][DEB-1] != m_out[ch]) s = 0;
        return s;
    endfunction

    function automatic int model_levels();
        return int'({m_out[3], m_out[2], m_out[1], m_out[0]});
    endfunction

    // Drive in the low phase, let one rising edge happen, compare on the falling edge.
    task automatic step(input logic [3:0] raw, input logic clr);
        {raw_h, raw_l, raw_u, raw_b} = raw;
        clear_glitch = clr;
        @(posedge clock);
        model_edge(raw, clr);
        @(negedge clock);
        check("levels",       int'({H, L, U, B}), model_levels());
        check("changed",      int'(changed),      int'(m_chg));
        check("stable",       int'(stable),       model_stable());
        check("glitch_count", int'(glitch_count), m_gc);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic [3:0] exp_lv;
        logic       exp_chg;
        logic       exp_stb;
        int         exp_gc;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int   chg_pulses, u_edge, b_edge;
        logic pu, pb;
        logic [3:0] r;
        logic c;

        // raw_h rises and is held: H at edge k+9, counter busy k+2..k+8.
        for (int i = 0; i < 11; i++) begin
            tbl[i].raw     = 4'b1000;
            tbl[i].exp_lv  = (i >= 9) ? 4'b1000 : 4'b0000;
            tbl[i].exp_chg = (i == 9);
            tbl[i].exp_stb = !(i >= 2 && i <= 8);
            tbl[i].exp_gc  = 0;
        end

        model_reset();
        #1;
        check("reset_levels",  int'({H, L, U, B}), 0);
        check("reset_changed", int'(changed), 0);
        check("reset_stable",  int'(stable), 1);
        check("reset_gc",      int'(glitch_count), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].raw, 1'b0);
            check($sformatf("tbl_lv[%0d]", i),  int'({H, L, U, B}), int'(tbl[i].exp_lv));
            check($sformatf("tbl_chg[%0d]", i), int'(changed),      int'(tbl[i].exp_chg));
            check($sformatf("tbl_stb[%0d]", i), int'(stable),       int'(tbl[i].exp_stb));
            check($sformatf("tbl_gc[%0d]", i),  int'(glitch_count), tbl[i].exp_gc);
        end

        // 7-sample pulse on raw_l is rejected and counted once.
        for (int i = 0; i < 7; i++) step(4'b1100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(4'b1000, 1'b0);
            check("l_pulse_L", int'(L), 0);
        end
        check("l_pulse_gc",     int'(glitch_count), 1);
        check("l_pulse_stable", int'(stable), 1);

        // raw_u and raw_b rise together: same accept edge, one change pulse.
        chg_pulses = 0; u_edge = -1; b_edge = -1;
        for (int i = 0; i < 14; i++) begin
            pu = U; pb = B;
            step(4'b1011, 1'b0);
            if (changed) chg_pulses++;
            if (U && !pu) u_edge = i;
            if (B && !pb) b_edge = i;
        end
        check("ub_u_edge",     u_edge, 9);
        check("ub_same_edge",  u_edge, b_edge);
        check("ub_one_pulse",  chg_pulses, 1);

        // 300 two-sample dips on raw_b saturate the glitch counter.
        for (int g = 0; g < 300; g++) begin
            step(4'b1010, 1'b0);
            step(4'b1010, 1'b0);
            for (int i = 0; i < 4; i++) step(4'b1011, 1'b0);
        end
        check("sat_gc", int'(glitch_count), 255);
        check("sat_B",  int'(B), 1);

        // Clear lands on the very edge where a glitch is flagged.
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1011, 1'b0);
        step(4'b1011, 1'b0);
        check("pre_clr_gc", int'(glitch_count), 255);
        step(4'b1011, 1'b1);
        check("clr_gc", int'(glitch_count), 0);
        step(4'b1011, 1'b0);
        check("post_clr_gc", int'(glitch_count), 0);

        // Reset mid-debounce discards the pending rise of H.
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b0);
        for (int i = 0; i < 7; i++) step(4'b1000, 1'b0);
        check("pre_rst_stable", int'(stable), 0);
        #2 reset = 1'b0;
        #1;
        check("rst_H",      int'(H), 0);
        check("rst_stable", int'(stable), 1);
        check("rst_gc",     int'(glitch_count), 0);
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b1000, 1'b0);
            if (i == 8) check("fresh_H_edge9",  int'(H), 0);
            if (i == 9) check("fresh_H_edge10", int'(H), 1);
        end

        // Random traffic with sticky levels so both accepts and glitches occur.
        r = 4'b1000;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
            c = ($urandom_range(0, 49) == 0);
            step(r, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
